clk_div_select: RTL and testbench
=================================

Name: clk_div_select

Overview:
- Downstream consumer of the clock divider's tap outputs (div_by_2 … div_by_32, all generated in the `clk` domain).
- Selects one tap at run time and switches between taps glitch-free, under a valid/ready request handshake.
- Produces three things:
  - `clk_out`, a gated copy of the selected tap.
  - `tick`, a single-cycle clock-enable strobe on each rising edge of the selected tap.
  - `tick_cnt`, a wrapping count of ticks.

Parameters:
- NTAPS, 5, number of divider taps; tap i divides by 2^(i+1).
- SELW, 3, width of the select field.
- DEFAULT_SEL, 0, tap selected after reset.
- CNT_W, 8, width of `tick_cnt`.

Ports:
- clk  input  1  system clock (same clock as the divider).
- rst  input  1  reset: synchronous, active-high, single clock domain.
- div_taps  input  NTAPS  divider taps; bit0 = div_by_2 … bit4 = div_by_32; registered in the `clk` domain.
- sel  input  SELW  requested tap index.
- sel_valid  input  1  select request valid.
- sel_ready  output  1  block can accept a request.
- sel_err  output  1  one-cycle pulse: rejected out-of-range request.
- cur_sel  output  SELW  tap currently driving outputs.
- busy  output  1  switch in progress.
- clk_out  output  1  registered, gated copy of the selected tap.
- tick  output  1  one-cycle strobe per rising edge of the selected tap.
- tick_cnt  output  CNT_W  count of ticks, wraps.

Behaviour:
- Reset (rst=1 at a posedge), values take effect the next cycle:
  - state=RUN, cur_sel=DEFAULT_SEL, pending=0, taps_q=0.
  - clk_out=0, tick=0, tick_cnt=0, sel_err=0, busy=0, sel_ready=1.
  - Reset mid-switch abandons the switch.
- taps_q: registered copy of `div_taps` every cycle.
- rise: `div_taps[cur_sel] & ~taps_q[cur_sel]` (combinational).
- States RUN, DRAIN, HOLD. sel_ready=1 only in RUN; busy=1 in DRAIN and HOLD.
- RUN:
  - clk_out <= div_taps[cur_sel]; tick <= rise.
  - Accept a request on `sel_valid & sel_ready`.
  - sel >= NTAPS: sel_err=1 for the next cycle only; no state change.
  - sel == cur_sel: accepted, no-op.
  - Otherwise: pending <= sel, go to DRAIN.
- DRAIN:
  - clk_out <= div_taps[cur_sel]; tick <= rise, so the old tap keeps running.
  - When `div_taps[cur_sel]==0` is sampled: clk_out <= 0, go to HOLD.
  - If the old tap is already low on DRAIN entry, leave after one cycle.
- HOLD:
  - clk_out <= 0, tick <= 0.
  - When `div_taps[pending]==0` is sampled: cur_sel <= pending, go to RUN.
  - On the first RUN cycle, clk_out follows the new tap; a new-tap rise that cycle is a valid tick.
- Latency: clk_out and tick lag `div_taps` by exactly 1 cycle. tick is high in the cycle in which clk_out goes 0→1.
- Glitch-free guarantees:
  - No clk_out high pulse is shorter than the half-period of the old or the new tap.
  - No tick is issued during HOLD.
- tick_cnt increments on each cycle where tick=1 and wraps from 2^CNT_W−1 to 0. It is not cleared on a switch.
- sel_valid while sel_ready=0 is ignored; the requester must hold the request until ready.
- sel_err and acceptance are mutually exclusive; a same-value request never raises busy.

Test Plan:
- Reset with a free-running divider, DEFAULT_SEL=0 → clk_out toggles every cycle, 1 cycle behind div_taps[0]; tick every 2 cycles; tick_cnt=5 after 10 cycles.
- In RUN, sel=4, sel_valid=1 → busy=1 and sel_ready=0 until div_taps[0] is low and then div_taps[4] is low; cur_sel becomes 4; ticks thereafter every 32 cycles; no clk_out high pulse <1 cycle and no tick during HOLD.
- sel=6, sel_valid=1 in RUN → sel_err=1 for exactly 1 cycle; cur_sel, clk_out and tick unaffected.
- sel=cur_sel → no busy, no gap in tick cadence.
- sel_valid held during DRAIN with a different value → ignored until RUN, then accepted.
- rst=1 during HOLD → next cycle state RUN, cur_sel=DEFAULT_SEL, clk_out=0, tick_cnt=0.
- CNT_W=3, selection /2, run 18 cycles → tick_cnt wraps 7→0 and reads 1 at the end.

Source files
------------

// File: rtl/clk_div_select.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_select
// Purpose  : Run-time glitch-free selection of one clock-divider tap, producing
//            a gated clock copy, a rising-edge tick strobe and a tick counter.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_select #(
    parameter int NTAPS       = 5,
    parameter int SELW        = 3,
    parameter int DEFAULT_SEL = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NTAPS-1:0] div_taps,
    input  logic [SELW-1:0]  sel,
    input  logic             sel_valid,
    output logic             sel_ready,
    output logic             sel_err,
    output logic [SELW-1:0]  cur_sel,
    output logic             busy,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] tick_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam int               c_nsel        = 2 ** SELW;
    localparam logic [SELW-1:0]  c_default_sel = SELW'(DEFAULT_SEL);
    localparam logic [SELW:0]    c_ntaps       = (SELW + 1)'(NTAPS);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    state_t             r_state;
    logic [SELW-1:0]    r_cur_sel;
    logic [SELW-1:0]    r_pending;
    logic [NTAPS-1:0]   r_taps_q;
    logic               r_clk_out;
    logic               r_tick;
    logic               r_sel_err;
    logic [CNT_W-1:0]   r_tick_cnt;

    state_t             w_state_nxt;
    logic [SELW-1:0]    w_cur_nxt;
    logic [SELW-1:0]    w_pend_nxt;
    logic               w_clk_nxt;
    logic               w_tick_nxt;
    logic               w_err_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [c_nsel-1:0]  w_taps_ext;
    logic [c_nsel-1:0]  w_taps_q_ext;
    logic               w_cur_tap;
    logic               w_new_tap;
    logic               w_rise;

    // Zero-extend the taps to the full select range so any index is in bounds.
    for (genvar i = 0; i < c_nsel; i++) begin : g_ext
        if (i < NTAPS) begin : g_tap
            assign w_taps_ext[i]   = div_taps[i];
            assign w_taps_q_ext[i] = r_taps_q[i];
        end else begin : g_pad
            assign w_taps_ext[i]   = 1'b0;
            assign w_taps_q_ext[i] = 1'b0;
        end
    end

    assign w_cur_tap = w_taps_ext[r_cur_sel];
    assign w_new_tap = w_taps_ext[r_pending];
    assign w_rise    = w_cur_tap & ~w_taps_q_ext[r_cur_sel];

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur_sel;
        w_pend_nxt  = r_pending;
        w_clk_nxt   = w_cur_tap;
        w_tick_nxt  = w_rise;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_tick_cnt;

        case (r_state)
            S_RUN: begin
                if (sel_valid) begin
                    if ({1'b0, sel} >= c_ntaps) begin
                        w_err_nxt = 1'b1;
                    end else if (sel != r_cur_sel) begin
                        w_pend_nxt  = sel;
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Old tap keeps running until it is seen low, so its last
                // high phase is never truncated.
                if (!w_cur_tap) begin
                    w_clk_nxt   = 1'b0;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_clk_nxt  = 1'b0;
                w_tick_nxt = 1'b0;
                if (!w_new_tap) begin
                    w_cur_nxt   = r_pending;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_clk_nxt   = 1'b0;
                w_tick_nxt  = 1'b0;
                w_state_nxt = S_RUN;
            end
        endcase

        if (w_tick_nxt) begin
            w_cnt_nxt = r_tick_cnt + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_cur_sel  <= c_default_sel;
            r_pending  <= '0;
            r_taps_q   <= '0;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
            r_sel_err  <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_sel  <= w_cur_nxt;
            r_pending  <= w_pend_nxt;
            r_taps_q   <= div_taps;
            r_clk_out  <= w_clk_nxt;
            r_tick     <= w_tick_nxt;
            r_sel_err  <= w_err_nxt;
            r_tick_cnt <= w_cnt_nxt;
        end
    end

    assign sel_ready = (r_state == S_RUN);
    assign busy      = (r_state != S_RUN);
    assign sel_err   = r_sel_err;
    assign cur_sel   = r_cur_sel;
    assign clk_out   = r_clk_out;
    assign tick      = r_tick;
    assign tick_cnt  = r_tick_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_select
// Purpose  : Directed self-checking bench for clk_div_select driven by a
//            free-running 5-bit divider counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_select;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst3;
    logic [4:0] div_cnt;
    logic [2:0] sel;
    logic       sel_valid;
    logic [2:0] sel3;
    logic       sel_valid3;

    logic       sel_ready, sel_err, busy, clk_out, tick;
    logic [2:0] cur_sel;
    logic [7:0] tick_cnt;

    logic       sel_ready3, sel_err3, busy3, clk_out3, tick3;
    logic [2:0] cur_sel3;
    logic [2:0] tick_cnt3;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    clk_div_select u_dut (
        .clk       (clk),
        .rst       (rst),
        .div_taps  (div_cnt),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .sel_err   (sel_err),
        .cur_sel   (cur_sel),
        .busy      (busy),
        .clk_out   (clk_out),
        .tick      (tick),
        .tick_cnt  (tick_cnt)
    );

    clk_div_select #(.CNT_W(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst3),
        .div_taps  (div_cnt),
        .sel       (sel3),
        .sel_valid (sel_valid3),
        .sel_ready (sel_ready3),
        .sel_err   (sel_err3),
        .cur_sel   (cur_sel3),
        .busy      (busy3),
        .clk_out   (clk_out3),
        .tick      (tick3),
        .tick_cnt  (tick_cnt3)
    );

    // After each edge the divider advances, so div_cnt == cyc (mod 32).
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        div_cnt = div_cnt + 5'd1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rst3 = 1'b1; div_cnt = 5'd0;
        sel = 3'd0; sel_valid = 1'b0; sel3 = 3'd0; sel_valid3 = 1'b0;

        steps(2);
        chk("rst_cur_sel", 32'(cur_sel), 32'd0);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_cnt", 32'(tick_cnt), 32'd0);
        chk("rst_err", 32'(sel_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(sel_ready), 32'd1);
        rst = 1'b0;

        // Divide-by-2: clk_out and tick high on even cycles from cycle 4.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("div2_clk", 32'(clk_out), 32'(cyc % 2 == 0));
            chk("div2_tick", 32'(tick), 32'(cyc % 2 == 0));
        end
        chk("div2_cnt5", 32'(tick_cnt), 32'd5);

        // Out-of-range request.
        sel = 3'd6; sel_valid = 1'b1;
        step();
        chk("err_pulse", 32'(sel_err), 32'd1);
        chk("err_cur", 32'(cur_sel), 32'd0);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_clk", 32'(clk_out), 32'd0);
        chk("err_tick", 32'(tick), 32'd0);
        sel_valid = 1'b0;
        step();
        chk("err_clear", 32'(sel_err), 32'd0);
        chk("err_tick_next", 32'(tick), 32'd1);
        chk("err_clk_next", 32'(clk_out), 32'd1);

        // Same-value request.
        sel = 3'd0; sel_valid = 1'b1;
        step();
        chk("same_busy", 32'(busy), 32'd0);
        chk("same_ready", 32'(sel_ready), 32'd1);
        sel_valid = 1'b0;
        step();
        chk("same_tick", 32'(tick), 32'd1);
        chk("same_cnt", 32'(tick_cnt), 32'd7);

        // Switch /2 -> /32 while tap 4 is high: long HOLD.
        sel = 3'd4; sel_valid = 1'b1;
        step();
        chk("sw4_busy", 32'(busy), 32'd1);
        chk("sw4_ready", 32'(sel_ready), 32'd0);
        chk("sw4_cur_old", 32'(cur_sel), 32'd0);
        sel_valid = 1'b0;
        step();
        chk("drain_clk", 32'(clk_out), 32'd1);
        chk("drain_tick", 32'(tick), 32'd1);
        for (int i = 0; i < 14; i++) begin
            step();
            chk("hold_clk", 32'(clk_out), 32'd0);
            chk("hold_tick", 32'(tick), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        step();
        chk("sw4_done_busy", 32'(busy), 32'd0);
        chk("sw4_done_cur", 32'(cur_sel), 32'd4);
        for (int i = 0; i < 48; i++) begin
            step();
            chk("div32_tick", 32'(tick), 32'(cyc == 49 || cyc == 81));
            chk("div32_clk", 32'(clk_out), 32'((cyc >= 49 && cyc <= 64) || cyc == 81));
        end
        chk("div32_cnt", 32'(tick_cnt), 32'd10);

        // Request held with a new value during DRAIN is deferred until RUN.
        sel = 3'd1; sel_valid = 1'b1;
        step();
        chk("sw1_busy", 32'(busy), 32'd1);
        chk("sw1_clk", 32'(clk_out), 32'd1);
        sel = 3'd3;
        for (int i = 0; i < 14; i++) begin
            step();
            chk("drain32_clk", 32'(clk_out), 32'd1);
            chk("drain32_tick", 32'(tick), 32'd0);
            chk("drain32_cur", 32'(cur_sel), 32'd4);
        end
        step();
        chk("sw1_hold_clk", 32'(clk_out), 32'd0);
        chk("sw1_hold_busy", 32'(busy), 32'd1);
        step();
        chk("sw1_cur", 32'(cur_sel), 32'd1);
        chk("sw1_ready", 32'(sel_ready), 32'd1);
        step();
        chk("sw3_busy", 32'(busy), 32'd1);
        chk("sw3_tick", 32'(tick), 32'd1);
        chk("sw3_cnt", 32'(tick_cnt), 32'd11);
        sel_valid = 1'b0;
        step();
        chk("sw3_drain_clk", 32'(clk_out), 32'd1);
        chk("sw3_drain_tick", 32'(tick), 32'd0);
        step();
        chk("sw3_hold_clk", 32'(clk_out), 32'd0);
        step();
        chk("sw3_cur", 32'(cur_sel), 32'd3);
        chk("sw3_done_busy", 32'(busy), 32'd0);

        // Reset while in HOLD.
        steps(10);
        sel = 3'd4; sel_valid = 1'b1;
        step();
        chk("rh_busy", 32'(busy), 32'd1);
        sel_valid = 1'b0;
        steps(2);
        chk("rh_hold_busy", 32'(busy), 32'd1);
        chk("rh_hold_clk", 32'(clk_out), 32'd0);
        rst = 1'b1;
        step();
        chk("rh_cur", 32'(cur_sel), 32'd0);
        chk("rh_busy0", 32'(busy), 32'd0);
        chk("rh_ready", 32'(sel_ready), 32'd1);
        chk("rh_clk", 32'(clk_out), 32'd0);
        chk("rh_tick", 32'(tick), 32'd0);
        chk("rh_cnt", 32'(tick_cnt), 32'd0);
        rst = 1'b0; rst3 = 1'b0;

        // 3-bit counter wraps 7 -> 0 and reads 1 after 18 cycles.
        steps(14);
        chk("w3_cnt7", 32'(tick_cnt3), 32'd7);
        steps(2);
        chk("w3_cnt0", 32'(tick_cnt3), 32'd0);
        steps(2);
        chk("w3_cnt1", 32'(tick_cnt3), 32'd1);
        chk("main_cnt9", 32'(tick_cnt), 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
